// File: rtl/mathbox_pkg.sv
// ---------------------------------------------------------------------------
// mathbox_pkg
// Shared definitions for the Math Box microprogram sequencer: microword field
// positions, COND branch encodings and the sequencer FSM state type.
// No ports (package).
// ---------------------------------------------------------------------------
package mathbox_pkg;

    // Microword sequencing fields; every other bit is passed to the ALU as-is.
    localparam int BA_HI    = 23;
    localparam int BA_LO    = 16;
    localparam int HALT_BIT = 7;
    localparam int COND_HI  = 6;
    localparam int COND_LO  = 4;

    localparam int BA_W   = BA_HI - BA_LO + 1;
    localparam int COND_W = COND_HI - COND_LO + 1;
    localparam int LC_W   = 8;

    // COND encodings
    localparam logic [COND_W-1:0] COND_NEXT = 3'b000;  // PC+1
    localparam logic [COND_W-1:0] COND_JMP  = 3'b001;  // jump to BA
    localparam logic [COND_W-1:0] COND_JZ   = 3'b010;  // jump if zero
    localparam logic [COND_W-1:0] COND_JNZ  = 3'b011;  // jump if not zero
    localparam logic [COND_W-1:0] COND_JS   = 3'b100;  // jump if sign
    localparam logic [COND_W-1:0] COND_JC   = 3'b101;  // jump if carry
    localparam logic [COND_W-1:0] COND_LOOP = 3'b110;  // LC!=0: LC-1, jump
    localparam logic [COND_W-1:0] COND_LDLC = 3'b111;  // LC <= BA, PC+1

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2
    } state_t;

endpackage

// File: rtl/mbseq_next_addr.sv
// ---------------------------------------------------------------------------
// mbseq_next_addr
// Combinational next-PC / branch decision / loop-counter update for one
// microinstruction. The caller decides whether the result is committed
// (it is not on halting or watchdog-aborted words).
// Ports:
//   pc        in  current microprogram counter
//   lc        in  current loop counter
//   ba        in  BA field (branch address or loop count)
//   cond      in  COND field
//   alu_zero/alu_sign/alu_carry in  ALU status of previously issued word
//   next_pc   out address of the next microinstruction
//   next_lc   out loop counter after this microinstruction
// ---------------------------------------------------------------------------
module mbseq_next_addr
    import mathbox_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic [ADDR_W-1:0] pc,
    input  logic [LC_W-1:0]   lc,
    input  logic [BA_W-1:0]   ba,
    input  logic [COND_W-1:0] cond,
    input  logic              alu_zero,
    input  logic              alu_sign,
    input  logic              alu_carry,
    output logic [ADDR_W-1:0] next_pc,
    output logic [LC_W-1:0]   next_lc
);

    logic              take;
    logic [ADDR_W-1:0] pc_inc;

    // Natural modulo arithmetic gives the FF -> 00 wrap.
    assign pc_inc = pc + ADDR_W'(1);

    always_comb begin
        take    = 1'b0;
        next_lc = lc;
        case (cond)
            COND_JMP:  take = 1'b1;
            COND_JZ:   take = alu_zero;
            COND_JNZ:  take = ~alu_zero;
            COND_JS:   take = alu_sign;
            COND_JC:   take = alu_carry;
            COND_LOOP: begin
                if (lc != '0) begin
                    take    = 1'b1;
                    next_lc = lc - LC_W'(1);
                end
            end
            COND_LDLC: next_lc = ba;
            default:   take = 1'b0;
        endcase
    end

    assign next_pc = take ? ADDR_W'(ba) : pc_inc;

endmodule

// File: rtl/mathbox_sequencer.sv
// ---------------------------------------------------------------------------
// mathbox_sequencer
// Microprogram sequencer for the Math Box microcode ROM. On start it walks
// the ROM from start_addr, two cycles per microinstruction (FETCH, EXEC),
// issuing each microword to the ALU and following branch/loop/halt fields.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start, start_addr     CPU start pulse and entry address
//   rom_addr, rom_cs      ROM address / select (select high in FETCH only)
//   rom_dout              ROM data, valid the cycle after rom_addr
//   alu_zero/sign/carry   ALU status from the previously issued microword
//   uinstr, uinstr_valid  issued microword and its one-cycle strobe
//   busy                  run in progress
//   done                  one-cycle pulse on a halting microword
//   wdog_err              sticky watchdog abort flag, cleared by next start
// ---------------------------------------------------------------------------
module mathbox_sequencer
    import mathbox_pkg::*;
#(
    parameter int ADDR_W   = 8,
    parameter int WORD_W   = 24,
    parameter int WDOG_MAX = 1023
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              rom_cs,
    input  logic [WORD_W-1:0] rom_dout,
    input  logic              alu_zero,
    input  logic              alu_sign,
    input  logic              alu_carry,
    output logic [WORD_W-1:0] uinstr,
    output logic              uinstr_valid,
    output logic              busy,
    output logic              done,
    output logic              wdog_err
);

    localparam int              SC_W     = $clog2(WDOG_MAX + 1);
    localparam logic [SC_W-1:0] WDOG_LIM = SC_W'(WDOG_MAX);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [LC_W-1:0]   lc_q, lc_d;
    logic [SC_W-1:0]   step_q, step_d;
    logic [WORD_W-1:0] uinstr_q, uinstr_d;
    logic              wdog_q, wdog_d;

    logic [ADDR_W-1:0] next_pc;
    logic [LC_W-1:0]   next_lc;
    logic              halt;

    assign halt = rom_dout[HALT_BIT];

    mbseq_next_addr #(
        .ADDR_W (ADDR_W)
    ) u_next_addr (
        .pc        (pc_q),
        .lc        (lc_q),
        .ba        (rom_dout[BA_HI:BA_LO]),
        .cond      (rom_dout[COND_HI:COND_LO]),
        .alu_zero  (alu_zero),
        .alu_sign  (alu_sign),
        .alu_carry (alu_carry),
        .next_pc   (next_pc),
        .next_lc   (next_lc)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            pc_q     <= '0;
            lc_q     <= '0;
            step_q   <= '0;
            uinstr_q <= '0;
            wdog_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            lc_q     <= lc_d;
            step_q   <= step_d;
            uinstr_q <= uinstr_d;
            wdog_q   <= wdog_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        lc_d     = lc_q;
        step_d   = step_q;
        uinstr_d = uinstr_q;
        wdog_d   = wdog_q;
        case (state_q)
            ST_IDLE: begin
                // LC is deliberately left alone so programs can share it.
                if (start) begin
                    pc_d    = start_addr;
                    step_d  = '0;
                    wdog_d  = 1'b0;
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: state_d = ST_EXEC;
            ST_EXEC: begin
                uinstr_d = rom_dout;
                // Halt outranks the watchdog so a program ending exactly on
                // the limit still completes normally.
                if (halt) begin
                    state_d = ST_IDLE;
                end else if (step_q == WDOG_LIM) begin
                    wdog_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    pc_d    = next_pc;
                    lc_d    = next_lc;
                    step_d  = step_q + SC_W'(1);
                    state_d = ST_FETCH;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs: the issued word is presented straight from the ROM during
    // EXEC and held from uinstr_q afterwards.
    always_comb begin
        rom_addr     = pc_q;
        rom_cs       = (state_q == ST_FETCH);
        uinstr_valid = (state_q == ST_EXEC);
        uinstr       = (state_q == ST_EXEC) ? rom_dout : uinstr_q;
        busy         = (state_q != ST_IDLE);
        done         = (state_q == ST_EXEC) && halt;
        wdog_err     = wdog_q;
    end

endmodule

// File: tb/tb_mathbox_sequencer.sv
module tb_mathbox_sequencer;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  start_addr;
    logic [7:0]  rom_addr;
    logic        rom_cs;
    logic [23:0] rom_dout;
    logic        alu_zero, alu_sign, alu_carry;
    logic [23:0] uinstr;
    logic        uinstr_valid;
    logic        busy;
    logic        done;
    logic        wdog_err;

    mathbox_sequencer #(
        .ADDR_W   (8),
        .WORD_W   (24),
        .WDOG_MAX (5)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .start_addr   (start_addr),
        .rom_addr     (rom_addr),
        .rom_cs       (rom_cs),
        .rom_dout     (rom_dout),
        .alu_zero     (alu_zero),
        .alu_sign     (alu_sign),
        .alu_carry    (alu_carry),
        .uinstr       (uinstr),
        .uinstr_valid (uinstr_valid),
        .busy         (busy),
        .done         (done),
        .wdog_err     (wdog_err)
    );

    typedef struct {
        logic [7:0]  addr;
        logic [23:0] word;
        logic        done;
        int          rel;   // issue cycle relative to start, -1 = don't care
    } exp_t;

    exp_t        exp_q[$];
    logic [23:0] rom [256];
    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    int          start_cyc = 0;
    logic [7:0]  last_fetch = 8'h00;
    logic [2:0]  conds [5] = '{3'b001, 3'b010, 3'b011, 3'b100, 3'b101};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous-read ROM model
    always @(posedge clk) if (rom_cs) rom_dout <= rom[rom_addr];

    initial begin
        #100000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "simulation time limit");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [23:0] mkw(input logic [7:0] ba, input logic halt,
                                        input logic [2:0] cond, input logic [11:0] pay);
        return {ba, pay[11:4], halt, cond, pay[3:0]};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] a, input logic d, input int rel);
        exp_t it;
        it.addr = a;
        it.word = rom[a];
        it.done = d;
        it.rel  = rel;
        exp_q.push_back(it);
    endtask

    task automatic start_run(input logic [7:0] a);
        start_addr = a;
        start      = 1'b1;
        start_cyc  = cyc;
        tick();
        start      = 1'b0;
        chk("busy_after_start", busy, 1'b1);
        chk("wdog_clear_on_start", wdog_err, 1'b0);
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n;
        n = 0;
        while (busy && n < budget) begin
            tick();
            n++;
        end
        if (busy) chk({name, "_timeout"}, busy, 1'b0);
    endtask

    // Scoreboard monitor
    initial begin
        exp_t it;
        forever begin
            @(negedge clk);
            if (rom_cs) last_fetch = rom_addr;
            if (uinstr_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_issue", uinstr_valid, 1'b0);
                end else begin
                    it = exp_q.pop_front();
                    chk("issue_addr", last_fetch, it.addr);
                    chk("uinstr", uinstr, it.word);
                    chk("done_on_issue", done, it.done);
                    chk("busy_on_issue", busy, 1'b1);
                    if (it.rel >= 0) chk("issue_cycle", cyc - start_cyc, it.rel);
                end
            end else if (done) begin
                chk("done_without_issue", done, 1'b0);
            end
        end
    end

    // Stimulus
    initial begin
        logic [2:0] cnd;
        logic       fb;
        logic       taken;

        for (int i = 0; i < 256; i++) rom[i] = 24'h0;
        rom_dout   = 24'h0;
        rst_n      = 1'b0;
        start      = 1'b0;
        start_addr = 8'h00;
        alu_zero   = 1'b0;
        alu_sign   = 1'b0;
        alu_carry  = 1'b0;
        tick();
        tick();

        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_valid", uinstr_valid, 1'b0);
        chk("rst_rom_cs", rom_cs, 1'b0);
        chk("rst_rom_addr", rom_addr, 8'h00);
        chk("rst_uinstr", uinstr, 24'h0);
        chk("rst_wdog", wdog_err, 1'b0);
        rst_n = 1'b1;
        tick();

        // Linear run 10..12
        rom[8'h10] = mkw(8'h77, 1'b0, 3'b000, 12'hA11);
        rom[8'h11] = mkw(8'h66, 1'b0, 3'b000, 12'hB22);
        rom[8'h12] = mkw(8'h55, 1'b1, 3'b000, 12'hC33);
        push(8'h10, 1'b0, 2);
        push(8'h11, 1'b0, 4);
        push(8'h12, 1'b1, 6);
        start_run(8'h10);
        wait_idle(40, "linear");
        chk("linear_idle_busy", busy, 1'b0);
        chk("linear_hold_uinstr", uinstr, rom[8'h12]);
        chk("linear_drained", exp_q.size(), 0);

        // Conditional branches from 20 to 40 or 21
        rom[8'h40] = mkw(8'h00, 1'b1, 3'b000, 12'h404);
        rom[8'h21] = mkw(8'h00, 1'b1, 3'b000, 12'h212);
        for (int ci = 0; ci < 5; ci++) begin
            for (int f = 0; f < 2; f++) begin
                cnd = conds[ci];
                fb  = f[0];
                rom[8'h20] = mkw(8'h40, 1'b0, cnd, 12'h200 + 12'(ci * 2 + f));
                alu_zero  = (cnd == 3'b010 || cnd == 3'b011) ? fb : ~fb;
                alu_sign  = (cnd == 3'b100) ? fb : ~fb;
                alu_carry = (cnd == 3'b101) ? fb : ~fb;
                case (cnd)
                    3'b001:  taken = 1'b1;
                    3'b011:  taken = ~fb;
                    default: taken = fb;
                endcase
                push(8'h20, 1'b0, 2);
                push(taken ? 8'h40 : 8'h21, 1'b1, 4);
                start_run(8'h20);
                wait_idle(40, "branch");
                tick();
            end
        end
        chk("branch_drained", exp_q.size(), 0);
        alu_zero  = 1'b0;
        alu_sign  = 1'b0;
        alu_carry = 1'b0;

        // Loop: 30 loads LC=3, 31 loops four issues, 32 halts on the
        // watchdog-limit step (halt wins)
        rom[8'h30] = mkw(8'h03, 1'b0, 3'b111, 12'h300);
        rom[8'h31] = mkw(8'h31, 1'b0, 3'b110, 12'h311);
        rom[8'h32] = mkw(8'h00, 1'b1, 3'b000, 12'h322);
        push(8'h30, 1'b0, 2);
        for (int k = 0; k < 4; k++) push(8'h31, 1'b0, 4 + 2 * k);
        push(8'h32, 1'b1, 12);
        start_run(8'h30);
        wait_idle(40, "loop");
        chk("loop_drained", exp_q.size(), 0);
        chk("loop_no_wdog", wdog_err, 1'b0);

        // LC left at 0: a loop word must fall through
        rom[8'h50] = mkw(8'h60, 1'b0, 3'b110, 12'h500);
        rom[8'h51] = mkw(8'h00, 1'b1, 3'b000, 12'h511);
        rom[8'h60] = mkw(8'h00, 1'b1, 3'b000, 12'h600);
        push(8'h50, 1'b0, 2);
        push(8'h51, 1'b1, 4);
        start_run(8'h50);
        wait_idle(40, "lc_zero");
        chk("lc_zero_drained", exp_q.size(), 0);

        // Wrap and watchdog
        rom[8'hFE] = mkw(8'h90, 1'b0, 3'b000, 12'hFE0);
        rom[8'hFF] = mkw(8'h91, 1'b0, 3'b000, 12'hFF0);
        rom[8'h00] = mkw(8'h92, 1'b0, 3'b000, 12'h001);
        rom[8'h01] = mkw(8'h93, 1'b0, 3'b000, 12'h012);
        rom[8'h02] = mkw(8'h94, 1'b0, 3'b000, 12'h023);
        rom[8'h03] = mkw(8'h95, 1'b0, 3'b000, 12'h034);
        rom[8'h04] = mkw(8'h00, 1'b1, 3'b000, 12'h045);
        push(8'hFE, 1'b0, 2);
        push(8'hFF, 1'b0, 4);
        push(8'h00, 1'b0, 6);
        push(8'h01, 1'b0, 8);
        push(8'h02, 1'b0, 10);
        push(8'h03, 1'b0, 12);
        start_run(8'hFE);
        wait_idle(40, "wdog");
        chk("wdog_set", wdog_err, 1'b1);
        chk("wdog_busy_low", busy, 1'b0);
        tick();
        tick();
        chk("wdog_sticky", wdog_err, 1'b1);
        chk("wdog_drained", exp_q.size(), 0);

        // Restart clears the error
        push(8'h12, 1'b1, 2);
        start_run(8'h12);
        wait_idle(40, "restart");
        chk("restart_wdog", wdog_err, 1'b0);
        chk("restart_drained", exp_q.size(), 0);

        // Start while busy is ignored
        push(8'h10, 1'b0, 2);
        push(8'h11, 1'b0, 4);
        push(8'h12, 1'b1, 6);
        start_run(8'h10);
        tick();
        start_addr = 8'h20;
        start      = 1'b1;
        tick();
        start      = 1'b0;
        wait_idle(40, "busy_start");
        chk("busy_start_drained", exp_q.size(), 0);

        // Start coinciding with the halting EXEC is ignored
        push(8'h10, 1'b0, 2);
        push(8'h11, 1'b0, 4);
        push(8'h12, 1'b1, 6);
        start_run(8'h10);
        for (int n = 0; n < 20 && cyc < start_cyc + 6; n++) tick();
        chk("halt_exec_cycle", cyc - start_cyc, 6);
        start_addr = 8'h12;
        start      = 1'b1;
        tick();
        start      = 1'b0;
        chk("halt_start_ignored", busy, 1'b0);
        tick();
        chk("halt_start_ignored2", busy, 1'b0);
        chk("halt_start_drained", exp_q.size(), 0);

        // Reset in the middle of an EXEC
        push(8'h10, 1'b0, 2);
        start_run(8'h10);
        tick();
        tick();
        tick();
        chk("pre_reset_valid", uinstr_valid, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_valid", uinstr_valid, 1'b0);
        chk("mid_rst_done", done, 1'b0);
        chk("mid_rst_rom_cs", rom_cs, 1'b0);
        chk("mid_rst_rom_addr", rom_addr, 8'h00);
        chk("mid_rst_uinstr", uinstr, 24'h0);
        tick();
        tick();
        rst_n = 1'b1;
        for (int n = 0; n < 4; n++) tick();
        chk("post_rst_busy", busy, 1'b0);
        chk("post_rst_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
